// File: rtl/mem_access_ctrl.sv
// Word-to-byte access sequencer with round-robin arbitration between an
// instruction-fetch port (read-only) and a load/store port (read/write).
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [31:0]       ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_ready,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_ls_q, last_ls_d;
  logic              port_ls_q, port_ls_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       rbuf_q, rbuf_d;

  logic              grant_any;
  logic              grant_ls;
  logic [ADDR_W-1:0] req_addr;
  logic [4:0]        byte_lsb;
  logic              in_xfer;
  logic              in_resp;
  logic [31:0]       resp_rdata;

  // Request address bits above ADDR_W are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], ls_addr[31:ADDR_W]};

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_any = if_req | ls_req;
    grant_ls  = (if_req & ls_req) ? ~last_ls_q : ls_req;
    req_addr  = grant_ls ? ls_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    byte_lsb  = {cnt_q, 3'b000};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_ls_d = last_ls_q;
    port_ls_d = port_ls_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rbuf_d    = rbuf_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          port_ls_d = grant_ls;
          last_ls_d = grant_ls;
          addr_d    = req_addr;
          we_d      = grant_ls & ls_we;
          wdata_d   = grant_ls ? ls_wdata : '0;
          rbuf_d    = '0;
          cnt_d     = '0;
          if (req_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (!we_q) begin
          rbuf_d[byte_lsb +: 8] = mem_rdata;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_ls_q <= 1'b0;
      port_ls_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rbuf_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_ls_q <= last_ls_d;
      port_ls_q <= port_ls_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rbuf_q    <= rbuf_d;
    end
  end

  always_comb begin
    in_xfer    = (state_q == S_XFER);
    in_resp    = (state_q == S_RESP);
    resp_rdata = (we_q | err_q) ? '0 : rbuf_q;

    mem_addr   = in_xfer ? addr_q + ADDR_W'(cnt_q) : '0;
    mem_wdata  = in_xfer ? wdata_q[byte_lsb +: 8] : '0;
    mem_we     = in_xfer & we_q;

    if_ready   = in_resp & ~port_ls_q;
    if_rdata   = if_ready ? resp_rdata : '0;
    if_err     = if_ready & err_q;
    ls_ready   = in_resp & port_ls_q;
    ls_rdata   = ls_ready ? resp_rdata : '0;
    ls_err     = ls_ready & err_q;

    busy       = (state_q != S_IDLE);
  end

endmodule
